// File: rtl/alu_mc.sv
// alu_mc: registered ALU with an iterative multiply/divide unit.
// ALU ops complete in one cycle from IDLE; MULT/MULTU/DIV/DIVU run a
// WIDTH-step shift-add / restoring-subtract loop and return {hi, r}.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  input  logic             md_en,
  input  logic [1:0]       md_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } stateType;

  stateType r_state;
  stateType w_nextState;

  // Handshake
  logic w_accept;

  // Mul/div engine registers
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_accHi;
  logic [WIDTH-1:0] r_accLo;
  logic [WIDTH-1:0] r_opB;
  logic             r_isDiv;
  logic             r_negLo;
  logic             r_negHi;
  logic             r_ovfPend;
  logic             r_dbzPend;

  // Registered outputs
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hiOut;
  logic             r_zero;
  logic             r_carry;
  logic             r_negative;
  logic             r_overflow;
  logic             r_divByZero;
  logic             r_outValid;

  // ALU combinational results
  logic [WIDTH:0]   w_addFull;
  logic [WIDTH:0]   w_subFull;
  logic             w_ltu;
  logic             w_lts;
  logic             w_eq;
  logic [SHW-1:0]   w_shamt;
  logic [SHW-1:0]   w_srIdx;
  logic [SHW-1:0]   w_slIdx;
  logic [WIDTH-1:0] w_aluR;
  logic             w_aluZero;
  logic             w_aluCarry;
  logic             w_aluNeg;
  logic             w_aluOvf;

  // Mul/div combinational helpers
  logic             w_aNeg;
  logic             w_bNeg;
  logic [WIDTH-1:0] w_aMag;
  logic [WIDTH-1:0] w_bMag;
  logic             w_mdDbz;
  logic             w_mdOvf;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divShift;
  logic [WIDTH:0]   w_divDiff;
  logic [2*WIDTH-1:0] w_negProd;
  logic [WIDTH-1:0] w_negLo;
  logic [WIDTH-1:0] w_negHi;
  logic             w_mdZero;

  assign w_accept = in_valid & in_ready;

  assign w_addFull = {1'b0, a} + {1'b0, b};
  assign w_subFull = {1'b0, a} - {1'b0, b};
  assign w_ltu     = w_subFull[WIDTH];
  assign w_lts     = $signed(a) < $signed(b);
  assign w_eq      = (a == b);
  assign w_shamt   = a[SHW-1:0];
  assign w_srIdx   = w_shamt - SHW'(1);
  // (-shamt) mod WIDTH equals WIDTH-shamt for every non-zero shift amount
  assign w_slIdx   = -w_shamt;

  // Signed mul/div work on magnitudes; the most-negative value maps onto
  // itself, which is the correct unsigned magnitude.
  assign w_aNeg  = md_op[0] & a[WIDTH-1];
  assign w_bNeg  = md_op[0] & b[WIDTH-1];
  assign w_aMag  = w_aNeg ? -a : a;
  assign w_bMag  = w_bNeg ? -b : b;
  assign w_mdDbz = md_op[1] & (b == '0);
  assign w_mdOvf = (md_op == 2'b11) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  assign w_mulSum   = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opB} : '0);
  assign w_divShift = {r_accHi, r_accLo[WIDTH-1]};
  assign w_divDiff  = w_divShift - {1'b0, r_opB};
  assign w_negProd  = -{r_accHi, r_accLo};
  assign w_negLo    = -r_accLo;
  assign w_negHi    = -r_accHi;
  assign w_mdZero   = (r_accLo == '0) && (r_accHi == '0);

  // ALU result and next flag values; flags an op does not touch keep their value
  always_comb begin
    w_aluR     = '0;
    w_aluZero  = r_zero;
    w_aluCarry = r_carry;
    w_aluNeg   = r_negative;
    w_aluOvf   = r_overflow;
    casez (aluc)
      4'b0000: begin
        w_aluR     = w_addFull[WIDTH-1:0];
        w_aluCarry = w_addFull[WIDTH];
      end
      4'b0001: begin
        w_aluR     = w_subFull[WIDTH-1:0];
        w_aluCarry = w_ltu;
      end
      4'b0010: begin
        w_aluR   = w_addFull[WIDTH-1:0];
        w_aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (w_addFull[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0011: begin
        w_aluR   = w_subFull[WIDTH-1:0];
        w_aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (w_subFull[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0100: w_aluR = a & b;
      4'b0101: w_aluR = a | b;
      4'b0110: w_aluR = a ^ b;
      4'b0111: w_aluR = ~(a | b);
      4'b100?: w_aluR = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b1010: begin
        w_aluR     = {{(WIDTH-1){1'b0}}, w_ltu};
        w_aluZero  = w_eq;
        w_aluCarry = w_ltu;
      end
      4'b1011: begin
        w_aluR    = {{(WIDTH-1){1'b0}}, w_lts};
        w_aluZero = w_eq;
        w_aluNeg  = w_lts;
      end
      4'b1100: begin
        w_aluR     = $signed(b) >>> w_shamt;
        w_aluCarry = (w_shamt == '0) ? 1'b0 : b[w_srIdx];
      end
      4'b1101: begin
        w_aluR     = b >> w_shamt;
        w_aluCarry = (w_shamt == '0) ? 1'b0 : b[w_srIdx];
      end
      4'b111?: begin
        w_aluR     = b << w_shamt;
        w_aluCarry = (w_shamt == '0) ? 1'b0 : b[w_slIdx];
      end
      default: w_aluR = '0;
    endcase
    if (aluc[3:1] != 3'b101) begin
      w_aluZero = (w_aluR == '0);
      w_aluNeg  = w_aluR[WIDTH-1];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: MD ops run WIDTH steps plus a sign-correction cycle, then FIN
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && md_en) begin
          w_nextState = w_mdDbz ? FIN : RUN;
        end
      end
      RUN: begin
        if (r_cnt == CW'(WIDTH)) begin
          w_nextState = FIN;
        end
      end
      FIN:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: ready only when idle and out of reset
  always_comb begin
    in_ready = rst_n && (r_state == IDLE);
  end

  // Mul/div engine: latch magnitudes at accept, iterate in RUN, correct signs at the end of RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_opB     <= '0;
      r_isDiv   <= 1'b0;
      r_negLo   <= 1'b0;
      r_negHi   <= 1'b0;
      r_ovfPend <= 1'b0;
      r_dbzPend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && md_en) begin
            r_isDiv   <= md_op[1];
            r_cnt     <= '0;
            r_ovfPend <= w_mdOvf;
            r_dbzPend <= w_mdDbz;
            if (w_mdDbz) begin
              r_accLo <= '1;
              r_accHi <= a;
              r_negLo <= 1'b0;
              r_negHi <= 1'b0;
            end else begin
              r_accLo <= w_aMag;
              r_accHi <= '0;
              r_opB   <= w_bMag;
              r_negLo <= w_aNeg ^ w_bNeg;
              r_negHi <= md_op[1] ? w_aNeg : (w_aNeg ^ w_bNeg);
            end
          end
        end
        RUN: begin
          if (r_cnt != CW'(WIDTH)) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_isDiv) begin
              if (!w_divDiff[WIDTH]) begin
                r_accHi <= w_divDiff[WIDTH-1:0];
                r_accLo <= {r_accLo[WIDTH-2:0], 1'b1};
              end else begin
                r_accHi <= w_divShift[WIDTH-1:0];
                r_accLo <= {r_accLo[WIDTH-2:0], 1'b0};
              end
            end else begin
              r_accHi <= w_mulSum[WIDTH:1];
              r_accLo <= {w_mulSum[0], r_accLo[WIDTH-1:1]};
            end
          end else if (r_isDiv) begin
            if (r_negLo) r_accLo <= w_negLo;
            if (r_negHi) r_accHi <= w_negHi;
          end else if (r_negLo) begin
            {r_accHi, r_accLo} <= w_negProd;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output registers: ALU results at accept, MD results on the FIN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_hiOut     <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_negative  <= 1'b0;
      r_overflow  <= 1'b0;
      r_divByZero <= 1'b0;
      r_outValid  <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (w_accept) begin
        r_divByZero <= 1'b0;
        if (!md_en) begin
          r_result   <= w_aluR;
          r_zero     <= w_aluZero;
          r_carry    <= w_aluCarry;
          r_negative <= w_aluNeg;
          r_overflow <= w_aluOvf;
          r_outValid <= 1'b1;
        end
      end else if (r_state == FIN) begin
        r_result    <= r_accLo;
        r_hiOut     <= r_accHi;
        r_zero      <= w_mdZero;
        r_negative  <= r_isDiv ? r_accLo[WIDTH-1] : r_accHi[WIDTH-1];
        r_overflow  <= r_ovfPend;
        r_divByZero <= r_dbzPend;
        r_outValid  <= 1'b1;
      end
    end
  end

  assign out_valid   = r_outValid;
  assign r           = r_result;
  assign hi          = r_hiOut;
  assign zero        = r_zero;
  assign carry       = r_carry;
  assign negative    = r_negative;
  assign overflow    = r_overflow;
  assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc at WIDTH=32 with hand-computed expectations.
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic        md_en;
  logic [1:0]  md_op;
  logic        out_valid;
  logic [31:0] r;
  logic [31:0] hi;
  logic        zero;
  logic        carry;
  logic        negative;
  logic        overflow;
  logic        div_by_zero;

  int checkCount = 0;
  int failCount  = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .aluc        (aluc),
    .md_en       (md_en),
    .md_op       (md_op),
    .out_valid   (out_valid),
    .r           (r),
    .hi          (hi),
    .zero        (zero),
    .carry       (carry),
    .negative    (negative),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs outside the bounded loops
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one request for exactly one edge, then return #1 after that edge
  task automatic applyStimulus(input logic isMd, input logic [3:0] op, input logic [1:0] mop,
                               input logic [31:0] opA, input logic [31:0] opB);
    md_en    = isMd;
    aluc     = op;
    md_op    = mop;
    a        = opA;
    b        = opB;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid after an MD accept, counting edges and watching in_ready
  task automatic waitResult(output int edges, output logic readyBad);
    edges    = 0;
    readyBad = 1'b0;
    while (!out_valid && edges < 100) begin
      if (in_ready) readyBad = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  int   edges;
  logic readyBad;
  logic sawValid;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    aluc     = '0;
    md_en    = 1'b0;
    md_op    = '0;

    // Reset state
    #12;
    checkOutput("rst_ready", in_ready, 1'b0);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_r", r, 32'h0);
    checkOutput("rst_flags", {zero, carry, negative, overflow, div_by_zero}, 5'b0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_ready", in_ready, 1'b1);

    // ADD signed overflow
    applyStimulus(1'b0, 4'b0010, 2'b00, 32'h7FFF_FFFF, 32'h1);
    checkOutput("add_valid", out_valid, 1'b1);
    checkOutput("add_r", r, 32'h8000_0000);
    checkOutput("add_zno", {zero, negative, overflow}, 3'b011);

    // SUBU then SLTU back to back
    applyStimulus(1'b0, 4'b0001, 2'b00, 32'h1, 32'h2);
    checkOutput("subu_valid", out_valid, 1'b1);
    checkOutput("subu_r", r, 32'hFFFF_FFFF);
    checkOutput("subu_carry", carry, 1'b1);
    applyStimulus(1'b0, 4'b1010, 2'b00, 32'h1, 32'h2);
    checkOutput("sltu_valid", out_valid, 1'b1);
    checkOutput("sltu_r", r, 32'h1);
    checkOutput("sltu_cz", {carry, zero}, 2'b10);
    @(posedge clk);
    #1;
    checkOutput("pulse_end", out_valid, 1'b0);

    // Shifts
    applyStimulus(1'b0, 4'b1100, 2'b00, 32'h4, 32'h8000_0000);
    checkOutput("sra_r", r, 32'hF800_0000);
    checkOutput("sra_carry", carry, 1'b0);
    applyStimulus(1'b0, 4'b1110, 2'b00, 32'h0, 32'h1);
    checkOutput("sll0_r", r, 32'h1);
    checkOutput("sll0_carry", carry, 1'b0);
    applyStimulus(1'b0, 4'b1101, 2'b00, 32'h1, 32'h3);
    checkOutput("srl_r", r, 32'h1);
    checkOutput("srl_carry", carry, 1'b1);
    applyStimulus(1'b0, 4'b1111, 2'b00, 32'h1, 32'h8000_0001);
    checkOutput("sll1_r", r, 32'h2);
    checkOutput("sll1_carry", carry, 1'b1);

    // LUI, SLT, XOR
    applyStimulus(1'b0, 4'b1000, 2'b00, 32'h0, 32'h1234_ABCD);
    checkOutput("lui_r", r, 32'hABCD_0000);
    applyStimulus(1'b0, 4'b1011, 2'b00, 32'hFFFF_FFFF, 32'h1);
    checkOutput("slt_r", r, 32'h1);
    checkOutput("slt_zn", {zero, negative}, 2'b01);
    applyStimulus(1'b0, 4'b0110, 2'b00, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
    checkOutput("xor_zero", {r, zero}, {32'h0, 1'b1});

    // MULT -2 * 3, with an ALU request held during RUN that must be ignored
    applyStimulus(1'b1, 4'b0000, 2'b01, 32'hFFFF_FFFE, 32'h3);
    md_en    = 1'b0;
    aluc     = 4'b0000;
    a        = 32'h1111_1111;
    b        = 32'h2222_2222;
    in_valid = 1'b1;
    waitResult(edges, readyBad);
    in_valid = 1'b0;
    checkOutput("mult_latency", edges, 34);
    checkOutput("mult_busy", readyBad, 1'b0);
    checkOutput("mult_ready", in_ready, 1'b1);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_r", r, 32'hFFFF_FFFA);
    checkOutput("mult_zno", {zero, negative, overflow}, 3'b010);

    // MULTU full-range product
    applyStimulus(1'b1, 4'b0000, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitResult(edges, readyBad);
    checkOutput("multu_prod", {hi, r}, 64'hFFFF_FFFE_0000_0001);

    // DIV -7 / 2
    applyStimulus(1'b1, 4'b0000, 2'b11, 32'hFFFF_FFF9, 32'h2);
    waitResult(edges, readyBad);
    checkOutput("div_latency", edges, 34);
    checkOutput("div_r", r, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);
    checkOutput("div_flags", {zero, negative, overflow, div_by_zero}, 4'b0100);

    // DIVU by zero
    applyStimulus(1'b1, 4'b0000, 2'b10, 32'h1234_5678, 32'h0);
    waitResult(edges, readyBad);
    checkOutput("dbz_latency", edges, 1);
    checkOutput("dbz_flag", div_by_zero, 1'b1);
    checkOutput("dbz_r", r, 32'hFFFF_FFFF);
    checkOutput("dbz_hi", hi, 32'h1234_5678);

    // Next accepted ALU op clears div_by_zero, hi holds
    applyStimulus(1'b0, 4'b0000, 2'b00, 32'h2, 32'h3);
    checkOutput("clr_dbz", div_by_zero, 1'b0);
    checkOutput("hold_hi", hi, 32'h1234_5678);
    checkOutput("addu_r", r, 32'h5);

    // DIV overflow: most-negative / -1
    applyStimulus(1'b1, 4'b0000, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    waitResult(edges, readyBad);
    checkOutput("divovf_r", r, 32'h8000_0000);
    checkOutput("divovf_hi", hi, 32'h0);
    checkOutput("divovf_ovf", overflow, 1'b1);

    // Reset mid-RUN
    applyStimulus(1'b1, 4'b0000, 2'b00, 32'h0000_0100, 32'h0000_0010);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_r", {r, hi}, 64'h0);
    checkOutput("mrst_flags", {out_valid, zero, carry, negative, overflow, div_by_zero}, 6'b0);
    checkOutput("mrst_ready", in_ready, 1'b0);
    #7 rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("mrst_novalid", sawValid, 1'b0);
    checkOutput("mrst_ready_after", in_ready, 1'b1);
    applyStimulus(1'b0, 4'b0010, 2'b00, 32'h0000_0002, 32'h0000_0003);
    checkOutput("post_add_valid", out_valid, 1'b1);
    checkOutput("post_add_r", r, 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered successor to the team's combinational 32-bit ALU.
- Keeps the 4-bit aluc op map and the zero/carry/negative/overflow flag outputs, with every result registered.
- Adds an iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) that produces HI/LO results.
- Sits between the CPU decode stage and writeback, behind a valid/ready handshake.

Parameters:
- WIDTH, 32, datapath width; legal values are 8, 16, 32, 64.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A; for shifts, the shift amount is a[SHW-1:0].
- b  in  WIDTH  operand B.
- aluc  in  4  ALU op, used when md_en=0.
- md_en  in  1  1 selects the mul/div unit.
- md_op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- out_valid  out  1  one-cycle pulse: result/flags are valid.
- r  out  WIDTH  ALU result; product low half; quotient.
- hi  out  WIDTH  product high half; remainder; holds its value for ALU ops.
- zero  out  1  flag.
- carry  out  1  flag.
- negative  out  1  flag.
- overflow  out  1  flag.
- div_by_zero  out  1  set when a DIV/DIVU had b=0; cleared by the next accepted op.

Behaviour:
Reset (async, rst_n=0):
- All outputs and internal registers go to 0; state goes to IDLE.
- in_ready deasserts while in reset.
- Reset asserted mid-operation aborts the operation with no out_valid.

Handshake:
- An op is accepted on a rising edge where in_valid & in_ready.
- in_ready = 1 only in IDLE.
- There is no output backpressure; out_valid is a single-cycle pulse.

States: IDLE, RUN, FIN.
- ALU op (md_en=0): stays in IDLE. r and the flags are registered at the accept edge, so out_valid=1 during the following cycle. Back-to-back ALU ops are allowed, giving one result per cycle.
- MD op: IDLE -> RUN. RUN lasts exactly WIDTH cycles with one shift-add or restoring-subtract step per cycle. RUN -> FIN applies sign correction. FIN -> IDLE writes r/hi. out_valid and in_ready are both 1 in the cycle after the FIN edge, i.e. the result appears WIDTH+2 edges after accept.
- DIV/DIVU with b=0: goes straight to FIN with r = all ones, hi = a, div_by_zero=1.

ALU ops (flags not listed for an op hold their previous value):
- 0000 ADDU: r=a+b; carry = carry-out of bit WIDTH; zero, negative.
- 0010 ADD: r=a+b; overflow = (a,b same sign) and r differs in sign; zero, negative.
- 0001 SUBU: r=a-b; carry = borrow (a<b unsigned); zero, negative.
- 0011 SUB: r=a-b; overflow = (a,b differ in sign) and r sign != a sign; zero, negative.
- 0100 AND, 0101 OR, 0110 XOR, 0111 NOR: zero, negative.
- 100x LUI: r={b[WIDTH/2-1:0], zeros}; zero, negative.
- 1011 SLT: r=(signed a<b); zero=(a==b); negative=(signed a<b).
- 1010 SLTU: r=(a<b); zero=(a==b); carry=(a<b).
- 1100 SRA, 1101 SRL: b shifted right by shamt; carry = b[shamt-1], or 0 if shamt=0.
- 111x SLL: b shifted left by shamt; carry = b[WIDTH-shamt], or 0 if shamt=0.
- All shifts also update zero and negative.

MD ops:
- Signed variants compute on magnitudes, then correct signs in FIN.
- MULT/MULTU: {hi,r} = full 2*WIDTH product.
- DIV/DIVU: r = quotient, hi = remainder. Quotient truncates toward zero; remainder takes the sign of a.
- DIV with a = most-negative and b = -1: r = a, hi = 0, overflow=1.
- MD flags: zero = (r==0 and hi==0); negative = r[WIDTH-1] for DIV, hi[WIDTH-1] for MULT. carry is unchanged; overflow is 0 except in the case above.
- in_valid asserted during RUN/FIN is ignored (in_ready=0). Operands are latched at accept, so later input changes have no effect.

Test Plan (WIDTH=32):
- ADD a=7FFFFFFF, b=1 -> next cycle out_valid=1, r=80000000, overflow=1, negative=1, zero=0.
- SUBU a=1, b=2 then SLTU same operands on the following cycle -> r=FFFFFFFF, carry=1; then r=1, carry=1, zero=0. Two consecutive out_valid pulses.
- SRA b=80000000, a=4 -> r=F8000000, carry=0. SLL b=1, a=0 -> r=1, carry=0.
- MULT a=FFFFFFFE (-2), b=3 -> out_valid exactly 34 edges after accept; hi=FFFFFFFF, r=FFFFFFFA. in_ready=0 throughout RUN.
- DIV a=FFFFFFF9 (-7), b=2 -> r=FFFFFFFD, hi=FFFFFFFF. DIVU b=0 -> div_by_zero=1, r=FFFFFFFF, hi=a. DIV 80000000/FFFFFFFF -> overflow=1.
- rst_n pulsed low mid-RUN -> all outputs 0 immediately. No out_valid follows; in_ready=1 after release; a new ADD then completes normally.
